// File: rtl/gray2binary_ptr_sync_pkg.sv
// Shared defaults, FSM encoding and bit-count helper for the Gray pointer
// receive path of the async FIFO.
package gray2binary_ptr_sync_pkg;

  localparam int DEF_PTR_SIZE    = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int MAX_PTR_W       = 64;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_e;

  function automatic int unsigned popcount(input logic [MAX_PTR_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_PTR_W; i++) n = n + {31'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/gray_sync_chain.sv
// Multi-flop synchronizer for a Gray-coded bus; every stage resets to 0.
module gray_sync_chain #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] s_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) s_q <= '0;
    else         s_q <= {s_q[STAGES-2:0], d_i};
  end

  assign q_o = s_q[STAGES-1];

endmodule

// File: rtl/gray2binary_ptr_sync.sv
// Synchronizes a remote Gray pointer, decodes it to binary, reports the
// advance since the last value and flags multi-bit Gray transitions.
module gray2binary_ptr_sync
  import gray2binary_ptr_sync_pkg::*;
#(
  parameter int PTR_SIZE    = DEF_PTR_SIZE,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [PTR_SIZE-1:0] Gray_ptr_async,
  input  logic                Clr_err,
  output logic [PTR_SIZE-1:0] Binary_ptr,
  output logic                Ptr_upd,
  output logic [PTR_SIZE-1:0] Ptr_delta,
  output logic                Ptr_rdy,
  output logic                Gray_err
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 1);

  logic [PTR_SIZE-1:0] g_sync, g_prev_q;
  logic [PTR_SIZE-1:0] bin_d, bin_q, delta_d, delta_q;
  logic                upd_d, upd_q, err_d, err_q, multi_bit;
  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                rdy_q;

  gray_sync_chain #(
    .WIDTH  (PTR_SIZE),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (CLK),
    .rst_ni (RST),
    .d_i    (Gray_ptr_async),
    .q_o    (g_sync)
  );

  // MSB passes through; each lower bit folds in the decoded bit above it.
  always_comb begin
    bin_d = '0;
    bin_d[PTR_SIZE-1] = g_sync[PTR_SIZE-1];
    for (int i = PTR_SIZE - 2; i >= 0; i--) bin_d[i] = bin_d[i+1] ^ g_sync[i];
  end

  assign multi_bit = popcount(MAX_PTR_W'(g_sync ^ g_prev_q)) > 32'd1;
  assign delta_d   = bin_d - bin_q;
  assign upd_d     = (bin_d != bin_q);

  // A fresh violation must not be lost to a clear issued in the same cycle.
  always_comb begin
    err_d = err_q;
    if (multi_bit && state_q == ST_TRACK) err_d = 1'b1;
    else if (Clr_err)                     err_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      g_prev_q <= '0;
      bin_q    <= '0;
      delta_q  <= '0;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      g_prev_q <= g_sync;
      bin_q    <= bin_d;
      delta_q  <= delta_d;
      upd_q    <= upd_d;
      err_q    <= err_d;
    end
  end

  // Hold off error checking until reset zeros have drained from the chain.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else if (state_q == ST_INIT) begin
      if (cnt_q == CNT_W'(SYNC_STAGES)) begin
        state_q <= ST_TRACK;
        rdy_q   <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign Binary_ptr = bin_q;
  assign Ptr_upd    = upd_q;
  assign Ptr_delta  = delta_q;
  assign Ptr_rdy    = rdy_q;
  assign Gray_err   = err_q;

endmodule
